// File: rtl/ext_mem_loader_pkg.sv
// ext_mem_loader_pkg: state encoding, memory word sizes and stream header layout.
package ext_mem_loader_pkg;

  localparam int unsigned IMEM_BYTES_PER_WORD = 4;
  localparam int unsigned DMEM_BYTES_PER_WORD = 8;
  localparam int unsigned NI_LSB              = 0;
  localparam int unsigned ND_LSB              = 32;
  localparam int unsigned CNT_W               = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_LOAD_I = 3'd2,
    ST_LOAD_D = 3'd3,
    ST_VERIFY = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  // First beat of a frame: word counts for instruction and data memory.
  typedef struct packed {
    logic [CNT_W-1:0] n_d;
    logic [CNT_W-1:0] n_i;
  } hdr_t;

  // Pull the two count fields out of a header beat.
  function automatic hdr_t unpack_hdr(input logic [63:0] beat);
    hdr_t h;
    h.n_i = beat[NI_LSB +: CNT_W];
    h.n_d = beat[ND_LSB +: CNT_W];
    return h;
  endfunction

  // States in which a load is in progress.
  function automatic logic is_busy(input state_e s);
    return (s == ST_HDR) || (s == ST_LOAD_I) || (s == ST_LOAD_D) || (s == ST_VERIFY);
  endfunction

endpackage

// File: rtl/ext_mem_loader_word_counter.sv
// loader_word_counter: beat index with a loadable limit and a terminal-count flag.
module loader_word_counter #(
  parameter int unsigned CW = 10
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] limit_in,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] limit,
  output logic          last_c
);

  logic [CW-1:0] cnt_d, cnt_q;
  logic [CW-1:0] limit_d, limit_q;

  // Load restarts with a new limit, clear empties both, inc steps one word.
  always_comb begin
    cnt_d   = cnt_q;
    limit_d = limit_q;
    if (load) begin
      cnt_d   = '0;
      limit_d = limit_in;
    end else if (clr) begin
      cnt_d   = '0;
      limit_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q   <= '0;
      limit_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
    end
  end

  assign cnt    = cnt_q;
  assign limit  = limit_q;
  assign last_c = (limit_q != '0) && (cnt_q == CW'(limit_q - CW'(1)));

endmodule

// File: rtl/ext_mem_loader.sv
// ext_mem_loader: streams a framed image into imem then dmem and releases the CPU.
// Optional read-back checksum verify pass: define EXT_MEM_LOADER_VERIFY_EN.
module ext_mem_loader
  import ext_mem_loader_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 512,
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic        halt,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  input  logic        s_last,
  output logic [63:0] imem_addr_ext,
  output logic        imem_wen_ext,
  output logic        imem_ren_ext,
  output logic [31:0] imem_wdata_ext,
  input  logic [31:0] imem_rdata_ext,
  output logic [63:0] dmem_addr_ext,
  output logic        dmem_wen_ext,
  output logic        dmem_ren_ext,
  output logic [63:0] dmem_wdata_ext,
  input  logic [63:0] dmem_rdata_ext,
  output logic        cpu_enable,
  output logic        busy,
  output logic        error
);

  localparam int unsigned IW = $clog2(IMEM_WORDS) + 1;
  localparam int unsigned DW = $clog2(DMEM_WORDS) + 1;
`ifdef EXT_MEM_LOADER_VERIFY_EN
  localparam int unsigned VW = ((IW > DW) ? IW : DW) + 1;
  localparam state_e LOAD_EXIT = ST_VERIFY;
`else
  localparam state_e LOAD_EXIT = ST_RUN;
`endif

  state_e        state_d, state_q;
  logic          s_ready_d, s_ready_q;
  logic          busy_d, busy_q;
  logic          error_d, error_q;
  logic          cpu_enable_d, cpu_enable_q;
  logic          imem_wen_d, imem_wen_q;
  logic [63:0]   imem_addr_d, imem_addr_q;
  logic [31:0]   imem_wdata_d, imem_wdata_q;
  logic          dmem_wen_d, dmem_wen_q;
  logic [63:0]   dmem_addr_d, dmem_addr_q;
  logic [63:0]   dmem_wdata_d, dmem_wdata_q;

  logic          i_clr, i_load, i_inc, i_last;
  logic          d_clr, d_load, d_inc, d_last;
  logic [IW-1:0] i_cnt, i_lim;
  logic [DW-1:0] d_cnt, d_lim;
  logic          i_empty, d_empty;
  logic          accept, write_i, write_d;
  hdr_t          hdr;

`ifdef EXT_MEM_LOADER_VERIFY_EN
  logic          imem_ren_d, imem_ren_q;
  logic          dmem_ren_d, dmem_ren_q;
  logic [63:0]   sum_w_d, sum_w_q;
  logic [63:0]   sum_r_d, sum_r_q;
  logic [VW-1:0] vcnt_d, vcnt_q;
  logic [VW-1:0] v_total;
  assign v_total = VW'(i_lim) + VW'(d_lim);
`endif

  assign hdr     = unpack_hdr(s_data);
  assign accept  = s_valid && s_ready_q && !halt;
  assign i_empty = (i_lim == '0);
  assign d_empty = (d_lim == '0);

  loader_word_counter #(.CW(IW)) u_icnt (
    .clk(clk), .arst_n(arst_n), .clr(i_clr), .load(i_load),
    .limit_in(IW'(hdr.n_i)), .inc(i_inc), .cnt(i_cnt), .limit(i_lim), .last_c(i_last)
  );

  loader_word_counter #(.CW(DW)) u_dcnt (
    .clk(clk), .arst_n(arst_n), .clr(d_clr), .load(d_load),
    .limit_in(DW'(hdr.n_d)), .inc(d_inc), .cnt(d_cnt), .limit(d_lim), .last_c(d_last)
  );

  // Frame sequencing, s_last checking and write/read strobe generation.
  always_comb begin
    state_d      = state_q;
    error_d      = error_q;
    imem_wen_d   = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    dmem_wen_d   = 1'b0;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    i_clr = 1'b0; i_load = 1'b0; i_inc = 1'b0;
    d_clr = 1'b0; d_load = 1'b0; d_inc = 1'b0;
    write_i = 1'b0;
    write_d = 1'b0;
`ifdef EXT_MEM_LOADER_VERIFY_EN
    imem_ren_d = 1'b0;
    dmem_ren_d = 1'b0;
    sum_w_d    = sum_w_q;
    vcnt_d     = vcnt_q;
    sum_r_d    = sum_r_q;
    if (imem_ren_q)      sum_r_d = sum_r_q + 64'(imem_rdata_ext);
    else if (dmem_ren_q) sum_r_d = sum_r_q + dmem_rdata_ext;
`endif

    if (halt) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_RUN, ST_ERR: begin
          if (start) begin
            state_d = ST_HDR;
            error_d = 1'b0;
            i_clr   = 1'b1;
            d_clr   = 1'b1;
`ifdef EXT_MEM_LOADER_VERIFY_EN
            sum_w_d = '0;
            sum_r_d = '0;
            vcnt_d  = '0;
`endif
          end
        end
        ST_HDR: begin
          if (accept) begin
            i_load = 1'b1;
            d_load = 1'b1;
            if ((hdr.n_i > CNT_W'(IMEM_WORDS)) || (hdr.n_d > CNT_W'(DMEM_WORDS)))
              state_d = ST_ERR;
            else if ((hdr.n_i == '0) && (hdr.n_d == '0))
              state_d = s_last ? LOAD_EXIT : ST_ERR;
            else if (s_last)
              state_d = ST_ERR;
            else
              state_d = (hdr.n_i != '0) ? ST_LOAD_I : ST_LOAD_D;
          end
        end
        ST_LOAD_I: begin
          if (accept) begin
            if (s_last != (i_last && d_empty)) begin
              state_d = ST_ERR;
            end else begin
              write_i = 1'b1;
              i_inc   = 1'b1;
              if (i_last) state_d = d_empty ? LOAD_EXIT : ST_LOAD_D;
            end
          end
        end
        ST_LOAD_D: begin
          if (accept) begin
            if (s_last != d_last) begin
              state_d = ST_ERR;
            end else begin
              write_d = 1'b1;
              d_inc   = 1'b1;
              if (d_last) state_d = LOAD_EXIT;
            end
          end
        end
`ifdef EXT_MEM_LOADER_VERIFY_EN
        ST_VERIFY: begin
          vcnt_d = vcnt_q + VW'(1);
          if (vcnt_q < v_total) begin
            if (vcnt_q < VW'(i_lim)) begin
              imem_ren_d  = 1'b1;
              imem_addr_d = 64'(vcnt_q) * 64'(IMEM_BYTES_PER_WORD);
            end else begin
              dmem_ren_d  = 1'b1;
              dmem_addr_d = 64'(VW'(vcnt_q - VW'(i_lim))) * 64'(DMEM_BYTES_PER_WORD);
            end
          end
          if (vcnt_q == v_total) state_d = (sum_r_d == sum_w_q) ? ST_RUN : ST_ERR;
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end

    if (write_i) begin
      imem_wen_d   = 1'b1;
      imem_addr_d  = 64'(i_cnt) * 64'(IMEM_BYTES_PER_WORD);
      imem_wdata_d = s_data[31:0];
`ifdef EXT_MEM_LOADER_VERIFY_EN
      sum_w_d = sum_w_q + 64'(s_data[31:0]);
`endif
    end
    if (write_d) begin
      dmem_wen_d   = 1'b1;
      dmem_addr_d  = 64'(d_cnt) * 64'(DMEM_BYTES_PER_WORD);
      dmem_wdata_d = s_data;
`ifdef EXT_MEM_LOADER_VERIFY_EN
      sum_w_d = sum_w_q + s_data;
`endif
    end

    if (state_d == ST_ERR) error_d = 1'b1;
    s_ready_d    = (state_d == ST_HDR) || (state_d == ST_LOAD_I) || (state_d == ST_LOAD_D);
    busy_d       = is_busy(state_d);
    cpu_enable_d = (state_q == ST_RUN) && (state_d == ST_RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_IDLE;
      s_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_enable_q <= 1'b0;
      imem_wen_q   <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_wen_q   <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
`ifdef EXT_MEM_LOADER_VERIFY_EN
      imem_ren_q   <= 1'b0;
      dmem_ren_q   <= 1'b0;
      sum_w_q      <= '0;
      sum_r_q      <= '0;
      vcnt_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      s_ready_q    <= s_ready_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
      cpu_enable_q <= cpu_enable_d;
      imem_wen_q   <= imem_wen_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      dmem_wen_q   <= dmem_wen_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
`ifdef EXT_MEM_LOADER_VERIFY_EN
      imem_ren_q   <= imem_ren_d;
      dmem_ren_q   <= dmem_ren_d;
      sum_w_q      <= sum_w_d;
      sum_r_q      <= sum_r_d;
      vcnt_q       <= vcnt_d;
`endif
    end
  end

  assign s_ready        = s_ready_q;
  assign busy           = busy_q;
  assign error          = error_q;
  assign cpu_enable     = cpu_enable_q;
  assign imem_wen_ext   = imem_wen_q;
  assign imem_addr_ext  = imem_addr_q;
  assign imem_wdata_ext = imem_wdata_q;
  assign dmem_wen_ext   = dmem_wen_q;
  assign dmem_addr_ext  = dmem_addr_q;
  assign dmem_wdata_ext = dmem_wdata_q;

`ifdef EXT_MEM_LOADER_VERIFY_EN
  assign imem_ren_ext = imem_ren_q;
  assign dmem_ren_ext = dmem_ren_q;
`else
  // Read-back path is not built; read data is intentionally ignored.
  logic unused_rdata;
  assign unused_rdata = ^{imem_rdata_ext, dmem_rdata_ext};
  assign imem_ren_ext = 1'b0;
  assign dmem_ren_ext = 1'b0;
`endif

endmodule

// File: tb/tb_ext_mem_loader.sv
// tb_ext_mem_loader: table, hand-written and random frames checked against a frame-level model.
`timescale 1ns/1ps
module tb_ext_mem_loader;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic [63:0] s_data = '0;
  logic        s_ready;
  logic [63:0] imem_addr_ext, dmem_addr_ext, dmem_wdata_ext;
  logic        imem_wen_ext, imem_ren_ext, dmem_wen_ext, dmem_ren_ext;
  logic [31:0] imem_wdata_ext;
  logic [31:0] imem_rdata_ext = '0;
  logic [63:0] dmem_rdata_ext = '0;
  logic        cpu_enable, busy, error;

  always #5 clk = ~clk;

  ext_mem_loader dut (
    .clk(clk), .arst_n(arst_n), .start(start), .halt(halt),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .imem_addr_ext(imem_addr_ext), .imem_wen_ext(imem_wen_ext), .imem_ren_ext(imem_ren_ext),
    .imem_wdata_ext(imem_wdata_ext), .imem_rdata_ext(imem_rdata_ext),
    .dmem_addr_ext(dmem_addr_ext), .dmem_wen_ext(dmem_wen_ext), .dmem_ren_ext(dmem_ren_ext),
    .dmem_wdata_ext(dmem_wdata_ext), .dmem_rdata_ext(dmem_rdata_ext),
    .cpu_enable(cpu_enable), .busy(busy), .error(error)
  );

  typedef struct { logic [63:0] addr; logic [63:0] data; } wr_t;
  typedef struct {
    int unsigned n_i;
    int unsigned n_d;
    int          last_idx;
    bit          gaps;
    bit          exp_err;
  } vec_t;

  wr_t         got_i[$], got_d[$], exp_i[$], exp_d[$];
  logic [63:0] beat_data[$];
  bit          beat_last[$];
  int          tests = 0;
  int          fails = 0;
  bit          both_wen = 1'b0;
  vec_t        vecs[13];

  // Record every memory write the DUT issues.
  always @(negedge clk) begin
    if (imem_wen_ext) got_i.push_back('{imem_addr_ext, 64'(imem_wdata_ext)});
    if (dmem_wen_ext) got_d.push_back('{dmem_addr_ext, dmem_wdata_ext});
    if (imem_wen_ext && dmem_wen_ext) both_wen = 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Frame: header {n_d, n_i} then n_i+n_d random payload beats; s_last on beat last_idx.
  task automatic build_frame(input int unsigned n_i, input int unsigned n_d, input int last_idx);
    int nb;
    beat_data.delete();
    beat_last.delete();
    nb = (n_i > 512 || n_d > 1024) ? 1 : int'(1 + n_i + n_d);
    for (int b = 0; b < nb; b++) begin
      beat_data.push_back((b == 0) ? {n_d, n_i} : {$urandom, $urandom});
      beat_last.push_back(b == last_idx);
    end
  endtask

  // Reference: expected writes, error outcome and how many beats the loader takes.
  task automatic model_frame(input int unsigned n_i, input int unsigned n_d,
                             output bit err, output int nacc);
    int unsigned total;
    logic [63:0] w;
    exp_i.delete();
    exp_d.delete();
    err   = 1'b0;
    nacc  = 1;
    total = n_i + n_d;
    if (n_i > 512 || n_d > 1024) err = 1'b1;
    else if (total == 0) err = !beat_last[0];
    else if (beat_last[0]) err = 1'b1;
    else begin
      for (int b = 1; b <= int'(total); b++) begin
        nacc++;
        if (beat_last[b] != (b == int'(total))) begin
          err = 1'b1;
          break;
        end
        w = beat_data[b];
        if (b <= int'(n_i)) exp_i.push_back('{64'((b - 1) * 4), {32'h0, w[31:0]}});
        else                exp_d.push_back('{64'((b - 1 - int'(n_i)) * 8), w});
      end
    end
  endtask

  task automatic start_pulse();
    @(negedge clk);
    got_i.delete();
    got_d.delete();
    both_wen = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present beats 0..nb-1; returns on the negedge after the last handshake.
  task automatic send_beats(input int nb, input bit gaps);
    int wait_cnt;
    for (int b = 0; b < nb; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = beat_data[b];
      s_last  = beat_last[b];
      wait_cnt = 0;
      while (!s_ready && wait_cnt < 20) begin
        @(negedge clk);
        wait_cnt++;
      end
      if (!s_ready) begin
        chk($sformatf("beat%0d_ready_timeout", b), 64'(s_ready), 64'd1);
        break;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_writes(input string nm);
    int mism = 0;
    chk({nm, "_imem_count"}, 64'(got_i.size()), 64'(exp_i.size()));
    chk({nm, "_dmem_count"}, 64'(got_d.size()), 64'(exp_d.size()));
    for (int i = 0; i < got_i.size() && i < exp_i.size(); i++)
      if (got_i[i].addr !== exp_i[i].addr || got_i[i].data !== exp_i[i].data) mism++;
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++)
      if (got_d[i].addr !== exp_d[i].addr || got_d[i].data !== exp_d[i].data) mism++;
    chk({nm, "_write_mismatches"}, 64'(mism), 64'd0);
    chk({nm, "_same_cycle_wen"}, 64'(both_wen), 64'd0);
  endtask

  task automatic run_frame(input string nm, input int unsigned n_i, input int unsigned n_d,
                           input int last_idx, input bit gaps, input bit exp_err, input bit use_model);
    bit merr;
    bit e;
    int nacc;
    build_frame(n_i, n_d, last_idx);
    model_frame(n_i, n_d, merr, nacc);
    e = use_model ? merr : exp_err;
    start_pulse();
    send_beats(nacc, gaps);
    repeat (3) @(negedge clk);
    chk({nm, "_error"}, 64'(error), 64'(e));
    chk({nm, "_cpu_enable"}, 64'(cpu_enable), 64'(!e));
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_s_ready"}, 64'(s_ready), 64'd0);
    check_writes(nm);
  endtask

  initial begin
    bit merr;
    int nacc;
    int unsigned ni, nd;
    int li;

    vecs[0]  = '{3,    2,    5,    1'b0, 1'b0};
    vecs[1]  = '{0,    0,    0,    1'b0, 1'b0};
    vecs[2]  = '{513,  0,    0,    1'b0, 1'b1};
    vecs[3]  = '{2,    0,    1,    1'b0, 1'b1};
    vecs[4]  = '{2,    1,    2,    1'b1, 1'b1};
    vecs[5]  = '{1,    1,    -1,   1'b0, 1'b1};
    vecs[6]  = '{0,    3,    3,    1'b1, 1'b0};
    vecs[7]  = '{512,  0,    512,  1'b0, 1'b0};
    vecs[8]  = '{0,    1024, 1024, 1'b0, 1'b0};
    vecs[9]  = '{0,    1025, 0,    1'b0, 1'b1};
    vecs[10] = '{4,    0,    0,    1'b0, 1'b1};
    vecs[11] = '{1,    0,    1,    1'b1, 1'b0};
    vecs[12] = '{0,    0,    -1,   1'b0, 1'b1};

    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_cpu_enable", 64'(cpu_enable), 64'd0);
    chk("rst_imem_wen", 64'(imem_wen_ext), 64'd0);
    chk("rst_dmem_wen", 64'(dmem_wen_ext), 64'd0);
    chk("rst_imem_ren", 64'(imem_ren_ext), 64'd0);
    chk("rst_dmem_ren", 64'(dmem_ren_ext), 64'd0);
    chk("rst_imem_addr", imem_addr_ext, 64'd0);
    chk("rst_dmem_addr", dmem_addr_ext, 64'd0);

    // Basic image: cpu_enable rises two cycles after the final beat handshake.
    build_frame(3, 2, 5);
    beat_data[1][31:0] = 32'h13;
    beat_data[2][31:0] = 32'h93;
    beat_data[3][31:0] = 32'h6F;
    model_frame(3, 2, merr, nacc);
    start_pulse();
    chk("tp_busy_in_hdr", 64'(busy), 64'd1);
    send_beats(nacc, 1'b0);
    chk("tp_last_dmem_wen", 64'(dmem_wen_ext), 64'd1);
    chk("tp_last_dmem_addr", dmem_addr_ext, 64'd8);
    chk("tp_cpu_en_1cyc", 64'(cpu_enable), 64'd0);
    @(negedge clk);
    chk("tp_cpu_en_2cyc", 64'(cpu_enable), 64'd1);
    chk("tp_imem_word2", {32'h0, imem_wdata_ext}, 64'h6F);
    repeat (2) @(negedge clk);
    check_writes("tp");

    // Oversized header errors; a fresh start clears error and reloads.
    build_frame(513, 0, 0);
    model_frame(513, 0, merr, nacc);
    start_pulse();
    send_beats(nacc, 1'b0);
    repeat (2) @(negedge clk);
    chk("big_error", 64'(error), 64'd1);
    chk("big_s_ready", 64'(s_ready), 64'd0);
    chk("big_cpu_enable", 64'(cpu_enable), 64'd0);
    build_frame(0, 0, 0);
    model_frame(0, 0, merr, nacc);
    start_pulse();
    chk("restart_error_cleared", 64'(error), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    send_beats(nacc, 1'b0);
    repeat (2) @(negedge clk);
    chk("restart_cpu_enable", 64'(cpu_enable), 64'd1);

    // Halt mid-LOAD_D with valid pattern 1,0,1,1: only accepted beats write.
    build_frame(1, 4, 5);
    model_frame(1, 4, merr, nacc);
    while (exp_d.size() > 2) void'(exp_d.pop_back());
    start_pulse();
    send_beats(3, 1'b0);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = beat_data[3];
    s_last  = 1'b0;
    @(negedge clk);
    halt    = 1'b1;
    s_data  = beat_data[4];
    s_last  = 1'b1;
    @(negedge clk);
    halt    = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("halt_busy", 64'(busy), 64'd0);
    chk("halt_s_ready", 64'(s_ready), 64'd0);
    chk("halt_cpu_enable", 64'(cpu_enable), 64'd0);
    repeat (3) @(negedge clk);
    check_writes("halt");

    // Asynchronous reset mid-load returns outputs to reset values at once.
    build_frame(4, 0, 4);
    model_frame(4, 0, merr, nacc);
    start_pulse();
    send_beats(3, 1'b0);
    arst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'd0);
    chk("midrst_imem_addr", imem_addr_ext, 64'd0);
    @(negedge clk);
    arst_n = 1'b1;

    for (int v = 0; v < 13; v++)
      run_frame($sformatf("vec%0d", v), vecs[v].n_i, vecs[v].n_d, vecs[v].last_idx,
                vecs[v].gaps, vecs[v].exp_err, 1'b0);

    for (int r = 0; r < 25; r++) begin
      ni = $urandom_range(0, 6);
      nd = $urandom_range(0, 6);
      case ($urandom_range(0, 4))
        0:       li = int'($urandom_range(0, ni + nd));
        1:       li = -1;
        default: li = int'(ni + nd);
      endcase
      run_frame($sformatf("rnd%0d", r), ni, nd, li, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
